// File: rtl/wb_burst_reader_if.sv
// Wishbone classic-pipelined read bus between the burst reader and a slave.
// Signals: wb_cyc, wb_stb, wb_we, wb_adr (initiator); wb_dat_i, wb_ack, wb_stall (slave).
interface wb_burst_reader_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          wb_cyc;
   logic          wb_stb;
   logic          wb_we;
   logic [AW-1:0] wb_adr;
   logic [DW-1:0] wb_dat_i;
   logic          wb_ack;
   logic          wb_stall;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_adr,
      input  wb_dat_i, wb_ack, wb_stall
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_adr,
      output wb_dat_i, wb_ack, wb_stall
   );
endinterface

// File: rtl/wb_burst_reader.sv
// Pipelined Wishbone burst reader: issues up to MAX_OUT reads of a contiguous
// block and streams the acked words out through a fall-through FIFO.
// Ports: clk, rst (sync, active-high); start/base_adr/length request;
// busy/done/err status; m_valid/m_ready/m_data stream; wb (master modport).
// Optional ack watchdog: define WB_BURST_READER_TIMEOUT_EN (limit TIMEOUT).
module wb_burst_reader #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int LEN_W   = 12,
   parameter int MAX_OUT = 4,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AW-1:0]    base_adr,
   input  logic [LEN_W-1:0] length,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [DW-1:0]    m_data,
   wb_burst_reader_if.master wb
);

   localparam int CW = $clog2(MAX_OUT) + 1;
   localparam int PW = $clog2(MAX_OUT);
   localparam logic [CW:0]   OUT_LIM = (CW+1)'(MAX_OUT);
   localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    adr_q;
   logic [LEN_W-1:0] rem_q;
   logic [CW-1:0]    inflight_q, inflight_d;
   logic [CW-1:0]    fifo_cnt_q;
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [DW-1:0]    mem_q [MAX_OUT];
   logic             busy_q, done_q;
   logic             cyc_c;

   logic start_ok, go, zero_go;
   logic credit, stb, accept, last_acc;
   logic ack_v, pop, fin, abort;

   assign start_ok = start & ~busy_q;
   assign go       = start_ok & (length != '0);
   assign zero_go  = start_ok & (length == '0);

   // Words already acked but not yet consumed still hold a FIFO slot,
   // so counting them here makes FIFO overflow impossible.
   assign credit   = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < OUT_LIM;
   assign stb      = (state_q == ISSUE) & credit;
   assign accept   = stb & ~wb.wb_stall;
   assign last_acc = accept & (rem_q == LEN_W'(1));

   assign ack_v    = wb.wb_ack & (inflight_q != '0);
   assign pop      = m_valid & m_ready;

   assign inflight_d = inflight_q + CW'(accept) - CW'(ack_v);

   // End of transfer: bus idle and the last buffered word leaving now.
   assign fin = busy_q & (state_q == IDLE) & (inflight_q == '0)
              & ((fifo_cnt_q == '0)
                 | ((fifo_cnt_q == CW'(1)) & pop));

   always_comb begin
      state_d = state_q;
      cyc_c   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (go) state_d = ISSUE;
         end
         ISSUE: begin
            cyc_c = 1'b1;
            if (last_acc) state_d = WAIT;
         end
         WAIT: begin
            cyc_c = 1'b1;
            if (inflight_d == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         adr_q      <= '0;
         rem_q      <= '0;
         inflight_q <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q <= state_d;

         if (go)          adr_q <= base_adr;
         else if (accept) adr_q <= adr_q + AW'(1);

         if (go)          rem_q <= length;
         else if (abort)  rem_q <= '0;
         else if (accept) rem_q <= rem_q - LEN_W'(1);

         inflight_q <= abort ? '0 : inflight_d;

         if (ack_v) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
         fifo_cnt_q <= fifo_cnt_q + CW'(ack_v) - CW'(pop);

         if (go)       busy_q <= 1'b1;
         else if (fin) busy_q <= 1'b0;

         done_q <= zero_go | fin;

         assert (!(ack_v && fifo_cnt_q == FULL_CNT));
         assert (MAX_OUT >= 2 && TIMEOUT > 0);
      end
   end

   always_ff @(posedge clk) begin
      if (ack_v) mem_q[wr_ptr_q] <= wb.wb_dat_i;
   end

`ifdef WB_BURST_READER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wd_q;
   logic          err_q;
   logic          tick;

   assign tick  = (inflight_q != '0) & ~wb.wb_ack;
   assign abort = tick & (wd_q == TW'(TIMEOUT - 1));
   assign err   = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         if (start_ok)   err_q <= 1'b0;
         else if (abort) err_q <= 1'b1;

         if (abort || !tick) wd_q <= '0;
         else                wd_q <= wd_q + TW'(1);
      end
   end
`else
   assign abort = 1'b0;
   assign err   = 1'b0;
`endif

   assign busy    = busy_q;
   assign done    = done_q;
   assign m_valid = (fifo_cnt_q != '0);
   // Gate the head so stale storage never shows after reset.
   assign m_data  = m_valid ? mem_q[rd_ptr_q] : '0;

   assign wb.wb_cyc = cyc_c;
   assign wb.wb_stb = stb;
   assign wb.wb_we  = 1'b0;
   assign wb.wb_adr = adr_q;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader: directed and randomized bursts
// against a queue-based slave and an in-order address/data reference.
module tb_wb_burst_reader;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int LW = 12;
   localparam int MO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_adr;
   logic [LW-1:0] length;
   logic          busy, done, err;
   logic          m_valid, m_ready;
   logic [DW-1:0] m_data;

   int checks = 0;
   int errors = 0;

   wb_burst_reader_if #(.AW(AW), .DW(DW)) bus ();

   wb_burst_reader #(
      .AW(AW), .DW(DW), .LEN_W(LW), .MAX_OUT(MO), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .base_adr(base_adr), .length(length),
      .busy(busy), .done(done), .err(err),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .wb(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] memf(input logic [15:0] a);
      return (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   // One burst: slave answers in order after 1..lat_max cycles.
   // stall_mode 0 none, 1 toggle, 2 random; ready_mode 0 high,
   // 1 random, 2 low until cycle 'hold'. abort_t>0 asserts rst then.
   task automatic xfer(input logic [15:0] base, input int len,
                       input int stall_mode, input int ready_mode,
                       input int hold, input int lat_max,
                       input int abort_t,
                       output int first_stb, output int cyc_fall);
      logic [15:0] pq_adr[$];
      int          pq_t[$];
      int          n_acc, n_out, n_done, t;
      logic        prev_hold, saw_cyc, ended;
      logic [15:0] prev_adr;
      n_acc = 0; n_out = 0; n_done = 0;
      prev_hold = 1'b0; saw_cyc = 1'b0; ended = 1'b0;
      prev_adr = '0;
      first_stb = -1; cyc_fall = -1;
      @(negedge clk);
      start = 1'b1; base_adr = base; length = LW'(len);
      bus.wb_stall = 1'b0; bus.wb_ack = 1'b0;
      m_ready = (ready_mode == 0);
      t = 1;
      while (!ended && t <= 3000) begin
         @(negedge clk);
         start = (t == 2);
         base_adr = 16'($urandom);
         length = LW'(5);
         if (abort_t == t) begin
            rst = 1'b1;
            bus.wb_ack = 1'b0;
            start = 1'b0;
            ended = 1'b1;
         end else begin
            if (bus.wb_stb && first_stb < 0) first_stb = t;
            if (bus.wb_cyc) saw_cyc = 1'b1;
            else if (saw_cyc && cyc_fall < 0) cyc_fall = t;
            chk("stb_without_cyc", 32'(bus.wb_stb & ~bus.wb_cyc), 0);
            chk("we_low", 32'(bus.wb_we), 0);
            chk("credit", 32'((n_acc - n_out) <= MO), 1);
            if (prev_hold) begin
               chk("stall_hold_stb", 32'(bus.wb_stb), 1);
               chk("stall_hold_adr", 32'(bus.wb_adr), 32'(prev_adr));
            end
            if (ready_mode == 2 && t == hold) begin
               chk("hold_accepts", n_acc, MO);
               chk("hold_stb", 32'(bus.wb_stb), 0);
               chk("hold_cyc", 32'(bus.wb_cyc), 1);
            end
            if (done) begin
               n_done++;
               chk("done_with_busy", 32'(busy), 0);
            end
            if (!busy) begin
               chk("done_once", n_done, 1);
               chk("end_cyc", 32'(bus.wb_cyc), 0);
               ended = 1'b1;
            end else begin
               case (stall_mode)
                  1: bus.wb_stall = (t % 2) == 1;
                  2: bus.wb_stall = ($urandom_range(0, 2) == 0);
                  default: bus.wb_stall = 1'b0;
               endcase
               case (ready_mode)
                  0: m_ready = 1'b1;
                  1: m_ready = ($urandom_range(0, 1) == 1);
                  default: m_ready = (t >= hold);
               endcase
               if (pq_t.size() > 0 && pq_t[0] <= t &&
                   (lat_max == 1 || $urandom_range(0, 3) != 0)) begin
                  bus.wb_ack = 1'b1;
                  bus.wb_dat_i = memf(pq_adr.pop_front());
                  void'(pq_t.pop_front());
               end else begin
                  bus.wb_ack = 1'b0;
                  bus.wb_dat_i = 16'($urandom);
               end
               if (bus.wb_stb && !bus.wb_stall) begin
                  chk("adr_order", 32'(bus.wb_adr), 32'(16'(base + n_acc)));
                  chk("acc_within_len", 32'(n_acc < len), 1);
                  pq_adr.push_back(bus.wb_adr);
                  pq_t.push_back(t + ((lat_max == 1) ? 1 :
                                 $urandom_range(1, lat_max)));
                  n_acc++;
               end
               if (m_valid && m_ready) begin
                  chk("data_order", 32'(m_data), 32'(memf(16'(base + n_out))));
                  n_out++;
               end
               prev_hold = bus.wb_stb && bus.wb_stall;
               prev_adr  = bus.wb_adr;
               t++;
            end
         end
      end
      if (!ended) chk("cycle_budget", 0, 1);
      bus.wb_ack = 1'b0; bus.wb_stall = 1'b0; start = 1'b0;
      if (abort_t == 0) begin
         chk("words_issued", n_acc, len);
         chk("words_out", n_out, len);
         chk("slave_drained", pq_t.size(), 0);
         for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("no_extra_done", 32'(done), 0);
         end
      end
   endtask

   initial begin
      int fs, cf;
      rst = 1'b1; start = 1'b0; base_adr = '0; length = '0;
      m_ready = 1'b0;
      bus.wb_ack = 1'b0; bus.wb_stall = 1'b0; bus.wb_dat_i = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_cyc", 32'(bus.wb_cyc), 0);
      chk("rst_stb", 32'(bus.wb_stb), 0);
      chk("rst_adr", 32'(bus.wb_adr), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_data", 32'(m_data), 0);

      xfer(16'h0100, 4, 0, 0, 0, 1, 0, fs, cf);
      chk("t1_first_stb", fs, 1);
      chk("t1_cyc_fall", cf, 6);

      xfer(16'h0500, 8, 0, 2, 20, 1, 0, fs, cf);
      xfer(16'h0300, 6, 1, 0, 0, 1, 0, fs, cf);

      @(negedge clk);
      start = 1'b1; length = '0; base_adr = 16'h0700;
      @(negedge clk);
      start = 1'b0;
      chk("zl_done", 32'(done), 1);
      chk("zl_busy", 32'(busy), 0);
      chk("zl_cyc", 32'(bus.wb_cyc), 0);
      chk("zl_valid", 32'(m_valid), 0);
      chk("zl_err", 32'(err), 0);
      @(negedge clk);
      chk("zl_done_once", 32'(done), 0);
      chk("zl_cyc2", 32'(bus.wb_cyc), 0);

      xfer(16'hFFFE, 4, 0, 1, 0, 2, 0, fs, cf);

      xfer(16'h0900, 8, 0, 2, 100, 1, 4, fs, cf);
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_cyc", 32'(bus.wb_cyc), 0);
      chk("mrst_stb", 32'(bus.wb_stb), 0);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_done", 32'(done), 0);
      chk("mrst_valid", 32'(m_valid), 0);
      chk("mrst_data", 32'(m_data), 0);
      m_ready = 1'b1;
      bus.wb_ack = 1'b1;
      bus.wb_dat_i = 16'hDEAD;
      @(negedge clk);
      bus.wb_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_ignored", 32'(m_valid), 0);
      chk("late_ack_no_done", 32'(done), 0);
      xfer(16'h0200, 2, 0, 0, 0, 1, 0, fs, cf);

      for (int k = 0; k < 6; k++) begin
         xfer(16'($urandom), $urandom_range(1, 24), 2, 1, 0, 3, 0, fs, cf);
      end

`ifdef WB_BURST_READER_TIMEOUT_EN
      @(negedge clk);
      start = 1'b1; base_adr = 16'h0400; length = LW'(2);
      m_ready = 1'b1; bus.wb_ack = 1'b0; bus.wb_stall = 1'b0;
      for (int t = 1; t <= 20; t++) begin
         @(negedge clk);
         start = 1'b0;
         if (t == 17) begin
            chk("to_err_early", 32'(err), 0);
            chk("to_cyc_early", 32'(bus.wb_cyc), 1);
         end
         if (t == 18) begin
            chk("to_err", 32'(err), 1);
            chk("to_cyc", 32'(bus.wb_cyc), 0);
            chk("to_stb", 32'(bus.wb_stb), 0);
         end
         if (t == 19) begin
            chk("to_done", 32'(done), 1);
            chk("to_busy", 32'(busy), 0);
            bus.wb_ack = 1'b1;
         end
         if (t == 20) begin
            bus.wb_ack = 1'b0;
            chk("to_late_ack", 32'(m_valid), 0);
            chk("to_err_sticky", 32'(err), 1);
         end
      end
      @(negedge clk);
      start = 1'b1; length = '0;
      @(negedge clk);
      start = 1'b0;
      chk("to_err_cleared", 32'(err), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_burst_reader.md
Name: wb_burst_reader

Overview:
- Wishbone classic-pipelined initiator that reads a contiguous block of words and streams them out over a valid/ready port.
- Serves as the bus-master side for the on-chip pipelined slaves (RAM, peripherals), e.g. for memory-to-peripheral copy or a debug dump.
- Keeps up to MAX_OUT reads in flight.
- An internal FIFO absorbs every acked word, so back-pressure from the consumer never violates the bus protocol.

Parameters:
- AW, 16: Wishbone address width (word address).
- DW, 16: data width.
- LEN_W, 12: width of the transfer-length input.
- MAX_OUT, 4: maximum reads issued but not yet consumed; also the FIFO depth (power of 2, at least 2).
- TIMEOUT, 255: ack watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; sampled only when busy=0.
- base_adr  in  AW  first word address; captured when start is accepted.
- length  in  LEN_W  word count; captured when start is accepted; 0 is legal.
- busy  out  1  high from start acceptance until the last word is consumed.
- done  out  1  one-cycle pulse at transfer end.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream consumer ready.
- m_data  out  DW  stream data.
- wb_cyc  out  1  bus cycle.
- wb_stb  out  1  strobe.
- wb_we  out  1  tied 0.
- wb_adr  out  AW  address.
- wb_dat_i  in  DW  read data from the slave.
- wb_ack  in  1  slave acknowledge.
- wb_stall  in  1  slave stall.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; FIFO empty; counters 0. Reset mid-transfer drops wb_cyc/wb_stb in the next cycle, flushes the FIFO, and produces no done pulse.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: start with length!=0 -> ISSUE; latch adr=base_adr and remaining=length; busy=1.
- IDLE: start with length=0 -> done=1 in the next cycle; bus untouched; busy stays 0.
- ISSUE: wb_cyc=1. wb_stb=1 whenever credit is available, where credit = (inflight + fifo_count) < MAX_OUT.
- Request accepted when wb_stb & ~wb_stall. On accept: adr<=adr+1 (wraps mod 2^AW), remaining--, inflight++.
- While wb_stall=1, wb_stb and wb_adr hold unchanged. No skipped or duplicated addresses.
- Last request accepted -> WAIT, with wb_stb=0 from the next cycle.
- WAIT: wb_cyc stays 1 until inflight==0. In the cycle after the last ack, wb_cyc=0 and the FSM returns to IDLE.
- Latency: start accepted at cycle 0 -> first wb_stb with wb_adr=base_adr at cycle 1.
- Ack handling: each wb_ack pushes wb_dat_i into the FIFO and decrements inflight. A simultaneous accept and ack leaves inflight unchanged.
- An ack arriving with inflight==0 is ignored: no push, no underflow.
- The credit rule guarantees no FIFO overflow. FIFO full plus a pending ack cannot occur; the assertion check flags it.
- Stream: m_valid = FIFO not empty; m_data = FIFO head (fall-through). A word acked at cycle n is visible at cycle n+1.
- Pop occurs on m_valid & m_ready. Simultaneous push and pop keeps the count constant.
- Words are emitted strictly in address order.
- busy: falls and done pulses in the same cycle, once the FSM is IDLE (cyc low), inflight==0, and the final word is popped. Exactly one done pulse per nonzero transfer.
- start while busy=1 is ignored.
- Length arithmetic is unsigned; the maximum transfer is 2^LEN_W-1 words.

Optional Feature:
- Macro: WB_BURST_READER_TIMEOUT_EN.
- When defined: a watchdog counts cycles with inflight>0 and no wb_ack, and resets to 0 on any ack.
  - On reaching TIMEOUT: err<=1, wb_cyc and wb_stb drop in the next cycle, inflight and remaining are cleared, and the FSM returns to IDLE.
  - Words already in the FIFO are still delivered. done then pulses when the FIFO empties.
  - Late acks after the abort are ignored.
- When undefined: no watchdog logic; err is tied 0; TIMEOUT is unused.

Test Plan:
- base_adr=0x0100, length=4, slave acks 1 cycle after accept, stall=0, m_ready=1 -> wb_adr 0x0100..0x0103 on cycles 1-4; m_data = mem[0x100..0x103] in order; wb_cyc low at cycle 6; single done pulse; busy=0 afterwards.
- length=8, MAX_OUT=4, m_ready=0 -> exactly 4 requests accepted, then wb_stb=0 with wb_cyc=1. Raise m_ready -> the remaining 4 are issued; 8 words are delivered in order; inflight+fifo_count never exceeds 4.
- length=6, wb_stall toggling 1/0 each cycle -> each address held while stalled; the accepted sequence is exactly base..base+5; 6 acks, 6 words out.
- start with length=0 -> done=1 at cycle 1; wb_cyc never asserted; m_valid stays 0.
- base_adr=0xFFFE, length=4 -> accepted addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rst asserted after 2 of 8 words are acked, then a new start with base 0x0200, length 2 -> after reset all outputs 0 and FIFO empty; the new transfer returns only mem[0x200..0x201]. With WB_BURST_READER_TIMEOUT_EN and TIMEOUT=16, withhold wb_ack -> err=1 and wb_cyc=0 17 cycles after the stb was accepted.
